// File: rtl/cluster_periph_arbiter.sv
// Purpose   : round-robin arbiter sharing one peripheral slave plug among NB_MASTERS core requesters,
//             with an in-order ID FIFO that routes each response back to the master that issued it.
// Latency   : request path is combinational (req/addr/data/gnt in the same cycle); responses are routed in the same cycle as r_valid_i.
// Backpress.: a stalled request (req_o & ~gnt_i) locks the selection; req_o drops while MAX_OUTSTANDING responses are pending.
// Ports     : clk_i/rst_ni clock and async active-low reset;
//             req_i/add_i/wen_i/wdata_i/be_i -> gnt_o, r_valid_o, r_rdata_o, r_opc_o on the master side;
//             req_o/add_o/wen_o/wdata_o/be_o/id_o <- gnt_i, r_valid_i, r_rdata_i, r_opc_i on the slave side;
//             outstanding_o is the pending-response count; resp_err_o is a sticky flag for responses that arrive with nothing pending.
module cluster_periph_arbiter #(
    parameter int NB_MASTERS      = 8,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    localparam int BE_WIDTH       = DATA_WIDTH / 8,
    localparam int IDW            = $clog2(NB_MASTERS),
    localparam int CNTW           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NB_MASTERS-1:0]                  req_i,
    input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0]  add_i,
    input  logic [NB_MASTERS-1:0]                  wen_i,
    input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [NB_MASTERS-1:0][BE_WIDTH-1:0]    be_i,
    output logic [NB_MASTERS-1:0]                  gnt_o,
    output logic [NB_MASTERS-1:0]                  r_valid_o,
    output logic [DATA_WIDTH-1:0]                  r_rdata_o,
    output logic                                   r_opc_o,
    output logic                                   req_o,
    output logic [ADDR_WIDTH-1:0]                  add_o,
    output logic                                   wen_o,
    output logic [DATA_WIDTH-1:0]                  wdata_o,
    output logic [BE_WIDTH-1:0]                    be_o,
    output logic [IDW-1:0]                         id_o,
    input  logic                                   gnt_i,
    input  logic                                   r_valid_i,
    input  logic [DATA_WIDTH-1:0]                  r_rdata_i,
    input  logic                                   r_opc_i,
    output logic [CNTW-1:0]                        outstanding_o,
    output logic                                   resp_err_o
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDW-1:0]                       ptr_q, ptr_d;
    logic                                 lock_q, lock_d;
    logic [IDW-1:0]                       lock_id_q, lock_id_d;
    logic                                 err_q, err_d;
    logic [CNTW-1:0]                      cnt_q, cnt_d;
    logic [PW-1:0]                        wr_q, wr_d;
    logic [PW-1:0]                        rd_q, rd_d;
    logic [MAX_OUTSTANDING-1:0][IDW-1:0]  fifo_q, fifo_d;

    logic           full;
    logic           push;
    logic           pop;
    logic           found;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] sel;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full = (cnt_q == CNTW'(MAX_OUTSTANDING));
    assign push = req_o & gnt_i;
    // A response with nothing pending is never routed; it only raises resp_err.
    assign pop  = r_valid_i & (cnt_q != '0);

    // Selection: a locked master keeps the plug while it still requests; if it
    // withdraws its request the lock is ignored and round-robin takes over.
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        cand  = '0;
        if (lock_q && req_i[lock_id_q]) begin
            sel   = lock_id_q;
            found = 1'b1;
        end else begin
            for (int i = 0; i < NB_MASTERS; i++) begin
                cand = IDW'((int'(ptr_q) + i) % NB_MASTERS);
                if (!found && req_i[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        req_o     = (|req_i) & ~full;
        add_o     = '0;
        wen_o     = 1'b0;
        wdata_o   = '0;
        be_o      = '0;
        id_o      = '0;
        gnt_o     = '0;
        r_valid_o = '0;
        r_rdata_o = '0;
        r_opc_o   = 1'b0;
        if (req_o) begin
            add_o   = add_i[sel];
            wen_o   = wen_i[sel];
            wdata_o = wdata_i[sel];
            be_o    = be_i[sel];
            id_o    = sel;
        end
        if (push) begin
            gnt_o[sel] = 1'b1;
        end
        if (pop) begin
            r_valid_o[fifo_q[rd_q]] = 1'b1;
            r_rdata_o               = r_rdata_i;
            r_opc_o                 = r_opc_i;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        lock_d    = 1'b0;
        lock_id_d = lock_id_q;
        err_d     = err_q | (r_valid_i & (cnt_q == '0));
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        fifo_d    = fifo_q;

        if (push) begin
            ptr_d        = IDW'((int'(sel) + 1) % NB_MASTERS);
            fifo_d[wr_q] = sel;
            wr_d         = wrap_inc(wr_q);
        end else if (req_o) begin
            // Stalled by the slave: hold this master until the handshake.
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

        if (pop) begin
            rd_d = wrap_inc(rd_q);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            fifo_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            fifo_q    <= fifo_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign resp_err_o    = err_q;

endmodule

// File: tb/tb_cluster_periph_arbiter.sv
// Purpose   : self-checking bench for cluster_periph_arbiter (NB_MASTERS=8, MAX_OUTSTANDING=2).
// Latency   : stimulus applied at the falling edge, outputs observed 2 time units later.
// Backpress.: gnt_i and r_valid_i are driven by the bench, both directed and random.
module tb_cluster_periph_arbiter;

    localparam int NB  = 8;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int MO  = 2;
    localparam int IDW = 3;
    localparam int CW  = 2;

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic [NB-1:0]             req_i = '0;
    logic [NB-1:0][AW-1:0]     add_i = '0;
    logic [NB-1:0]             wen_i = '0;
    logic [NB-1:0][DW-1:0]     wdata_i = '0;
    logic [NB-1:0][BW-1:0]     be_i = '0;
    logic [NB-1:0]             gnt_o;
    logic [NB-1:0]             r_valid_o;
    logic [DW-1:0]             r_rdata_o;
    logic                      r_opc_o;
    logic                      req_o;
    logic [AW-1:0]             add_o;
    logic                      wen_o;
    logic [DW-1:0]             wdata_o;
    logic [BW-1:0]             be_o;
    logic [IDW-1:0]            id_o;
    logic                      gnt_i = 1'b0;
    logic                      r_valid_i = 1'b0;
    logic [DW-1:0]             r_rdata_i = '0;
    logic                      r_opc_i = 1'b0;
    logic [CW-1:0]             outstanding_o;
    logic                      resp_err_o;

    always #5 clk_i = ~clk_i;

    cluster_periph_arbiter #(
        .NB_MASTERS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
        .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o), .id_o(id_o),
        .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .r_opc_i(r_opc_i),
        .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
    );

    typedef struct {
        int            id;
        logic [AW-1:0] add;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } gexp_t;

    typedef struct {
        int            id;
        logic [DW-1:0] d;
        logic          opc;
    } rexp_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending transactions are simply a queue of master ids.
    int    m_ptr = 0;
    bit    m_lock = 0;
    int    m_lock_id = 0;
    bit    m_err = 0;
    int    mq[$];
    gexp_t gq[$];
    rexp_t rq[$];

    // Expected per-cycle observables, captured before the model advances.
    bit s_req = 0;
    int s_out = 0;
    bit s_err = 0;
    int s_sel = 0;
    bit last_hs = 0;
    int last_sel = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int    n;
        int    sel;
        bit    found;
        bit    exp_req;
        gexp_t g;
        rexp_t r;
        n       = mq.size();
        exp_req = (req_i != 0) && (n != MO);
        sel     = m_ptr;
        found   = 0;
        if (m_lock && req_i[m_lock_id]) begin
            sel   = m_lock_id;
            found = 1;
        end else begin
            for (int k = 0; k < NB; k++) begin
                int c;
                c = (m_ptr + k) % NB;
                if (!found && req_i[c]) begin
                    sel   = c;
                    found = 1;
                end
            end
        end
        s_req = exp_req;
        s_out = n;
        s_err = m_err;
        s_sel = sel;
        last_hs  = exp_req && gnt_i;
        last_sel = sel;
        if (r_valid_i) begin
            if (n > 0) begin
                r.id  = mq.pop_front();
                r.d   = r_rdata_i;
                r.opc = r_opc_i;
                rq.push_back(r);
            end else begin
                m_err = 1;
            end
        end
        if (last_hs) begin
            g.id    = sel;
            g.add   = add_i[sel];
            g.wen   = wen_i[sel];
            g.wdata = wdata_i[sel];
            g.be    = be_i[sel];
            gq.push_back(g);
            mq.push_back(sel);
            m_ptr  = (sel + 1) % NB;
            m_lock = 0;
        end else begin
            m_lock    = exp_req;
            m_lock_id = sel;
        end
    endtask

    task automatic cycd(input logic [NB-1:0] rq_v, input logic g, input logic rv,
                        input logic [DW-1:0] rd, input logic opc);
        @(negedge clk_i);
        req_i = rq_v;
        gnt_i = g;
        r_valid_i = rv;
        r_rdata_i = rd;
        r_opc_i = opc;
        for (int k = 0; k < NB; k++) begin
            add_i[k]   = $urandom();
            wdata_i[k] = $urandom();
            be_i[k]    = BW'($urandom());
            wen_i[k]   = 1'($urandom_range(0, 1));
        end
        model_step();
    endtask

    task automatic cyc(input logic [NB-1:0] rq_v, input logic g, input logic rv);
        cycd(rq_v, g, rv, $urandom(), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        req_i = '0;
        gnt_i = 1'b0;
        r_valid_i = 1'b0;
        r_rdata_i = '0;
        r_opc_i = 1'b0;
        mq.delete();
        m_ptr = 0;
        m_lock = 0;
        m_err = 0;
        s_req = 0;
        s_out = 0;
        s_err = 0;
        #1;
        chk("rst_outstanding", 64'(outstanding_o), 0);
        chk("rst_resp_err", 64'(resp_err_o), 0);
        chk("rst_req_o", 64'(req_o), 0);
        chk("rst_gnt_rvalid", 64'({gnt_o, r_valid_o}), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Monitor: compares every cycle against the model snapshot and pops the
    // scoreboard queues whenever the DUT presents a grant or a response.
    initial begin
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_ni) begin
                chk("req_o", 64'(req_o), 64'(s_req));
                chk("outstanding_o", 64'(outstanding_o), 64'(s_out));
                chk("resp_err_o", 64'(resp_err_o), 64'(s_err));
                if (s_req) begin
                    chk("id_o", 64'(id_o), 64'(s_sel));
                end else begin
                    chk("idle_slave_bus", 64'(add_o) | 64'(wdata_o) | 64'({wen_o, be_o, id_o}), 0);
                end
                if (gnt_o != '0) begin
                    if (gq.size() == 0) begin
                        chk("unexpected_gnt", 64'(gnt_o), 0);
                    end else begin
                        g = gq.pop_front();
                        chk("gnt_o", 64'(gnt_o), 64'(1) << g.id);
                        chk("gnt_add", 64'(add_o), 64'(g.add));
                        chk("gnt_wdata", 64'({wen_o, be_o, wdata_o}), 64'({g.wen, g.be, g.wdata}));
                    end
                end
                if (r_valid_o != '0) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_rvalid", 64'(r_valid_o), 0);
                    end else begin
                        r = rq.pop_front();
                        chk("r_valid_o", 64'(r_valid_o), 64'(1) << r.id);
                        chk("r_rdata_o", 64'({r_opc_o, r_rdata_o}), 64'({r.opc, r.d}));
                    end
                end else begin
                    chk("idle_resp_bus", 64'({r_opc_o, r_rdata_o}), 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NB-1:0] rnd_req;

        // Round-robin sweep with every master requesting.
        do_reset();
        cyc(8'hFF, 1'b1, 1'b0);
        #2 chk("sweep_gnt_0", 64'(gnt_o), 64'h1);
        for (int i = 1; i <= NB; i++) begin
            cyc(8'hFF, 1'b1, 1'b1);
            #2 chk("sweep_gnt", 64'(gnt_o), 64'(1) << (i % NB));
        end
        cyc(8'h00, 1'b0, 1'b1);

        // Lock: master 3 stalled, master 1 arrives while stalled.
        do_reset();
        cyc(8'h08, 1'b0, 1'b0);
        cyc(8'h0A, 1'b0, 1'b0);
        cyc(8'h0A, 1'b0, 1'b0);
        #2 chk("lock_id", 64'(id_o), 3);
        cyc(8'h0A, 1'b1, 1'b0);
        #2 chk("lock_gnt3", 64'(gnt_o), 64'h08);
        cyc(8'h02, 1'b1, 1'b0);
        #2 chk("after_lock_gnt1", 64'(gnt_o), 64'h02);
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);

        // Full: two pending, requests blocked until a slot frees.
        cyc(8'hFF, 1'b1, 1'b0);
        cyc(8'hFF, 1'b1, 1'b0);
        cyc(8'hFF, 1'b1, 1'b0);
        #2 chk("full_req_o", 64'(req_o), 0);
        chk("full_outstanding", 64'(outstanding_o), 2);
        cyc(8'hFF, 1'b0, 1'b1);
        #2 chk("pop_full_req_o", 64'(req_o), 0);
        cyc(8'hFF, 1'b0, 1'b0);
        #2 chk("freed_req_o", 64'(req_o), 1);
        cyc(8'h00, 1'b0, 1'b1);

        // Response routing in grant order.
        do_reset();
        cyc(8'h20, 1'b1, 1'b0);
        cyc(8'h04, 1'b1, 1'b0);
        cycd(8'h00, 1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
        #2 chk("route_first", 64'({r_valid_o, r_rdata_o}), {32'h0, 8'h20, 32'hA5A5_0001});
        cycd(8'h00, 1'b0, 1'b1, 32'h0000_BEEF, 1'b1);
        #2 chk("route_second", 64'({r_valid_o, r_rdata_o}), {32'h0, 8'h04, 32'h0000_BEEF});

        // Unexpected response raises a sticky error.
        cyc(8'h00, 1'b0, 1'b1);
        #2 chk("unexp_no_rvalid", 64'(r_valid_o), 0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        #2 chk("err_sticky", 64'(resp_err_o), 1);

        // Reset with a response pending, then the pointer restarts at 0.
        cyc(8'h04, 1'b1, 1'b0);
        do_reset();
        cyc(8'h81, 1'b1, 1'b0);
        #2 chk("post_reset_gnt0", 64'(gnt_o), 64'h01);
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);

        // Randomized traffic; masters hold requests until served.
        rnd_req = '0;
        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < NB; k++) begin
                if (!rnd_req[k] && $urandom_range(0, 2) == 0) rnd_req[k] = 1'b1;
            end
            cyc(rnd_req, $urandom_range(0, 9) < 7, (mq.size() > 0) && ($urandom_range(0, 1) == 1));
            if (last_hs) rnd_req[last_sel] = 1'b0;
        end
        for (int n = 0; n < 4; n++) begin
            cyc(8'h00, 1'b0, mq.size() > 0);
        end
        @(negedge clk_i);
        #3;
        chk("gnt_queue_drained", 64'(gq.size()), 0);
        chk("resp_queue_drained", 64'(rq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cluster_periph_arbiter.md
CLUSTER_PERIPH_ARBITER -- requirements
Module: cluster_periph_arbiter

Interface
REQ-001 SHALL have parameter NB_MASTERS, default 8, number of core-side requesters sharing one peripheral slave plug (2..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, write/read data width; byte-enable width BE_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, granted-but-unanswered transactions tracked (1..4); IDW = clog2(NB_MASTERS).
REQ-005 SHALL have ports: clk_i  in  1  single clock, rising edge; rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have master ports: req_i in NB_MASTERS; add_i in NB_MASTERS x ADDR_WIDTH; wen_i in NB_MASTERS (1=read); wdata_i in NB_MASTERS x DATA_WIDTH; be_i in NB_MASTERS x BE_WIDTH; gnt_o out NB_MASTERS; r_valid_o out NB_MASTERS; r_rdata_o out DATA_WIDTH (shared); r_opc_o out 1 (shared, error flag).
REQ-007 SHALL have slave ports: req_o out 1; add_o out ADDR_WIDTH; wen_o out 1; wdata_o out DATA_WIDTH; be_o out BE_WIDTH; id_o out IDW granted master index; gnt_i in 1; r_valid_i in 1; r_rdata_i in DATA_WIDTH; r_opc_i in 1.
REQ-008 SHALL have status ports: outstanding_o out clog2(MAX_OUTSTANDING+1) count of pending responses; resp_err_o out 1 sticky unexpected-response flag.

Function
REQ-009 SHALL select among asserted req_i by round-robin: search from priority pointer ptr upward, wrapping at NB_MASTERS-1 to 0.
REQ-010 SHALL drive req_o = (any req_i) AND NOT full, where full = (outstanding count == MAX_OUTSTANDING), registered value.
REQ-011 SHALL drive add_o/wen_o/wdata_o/be_o/id_o combinationally from the selected master; all zero when req_o=0.
REQ-012 SHALL assert gnt_o[k] only when req_o=1, gnt_i=1, k is selected; at most one gnt_o bit high per cycle.
REQ-013 SHALL lock the selection: if req_o=1 and gnt_i=0, next cycle the same master stays selected regardless of ptr or new requests; lock clears on handshake.
REQ-014 SHALL, on handshake (req_o & gnt_i), set ptr = (k+1) mod NB_MASTERS and push k into an in-order ID FIFO of depth MAX_OUTSTANDING.
REQ-015 SHALL, on r_valid_i with FIFO non-empty, pop head h and assert r_valid_o[h] for exactly that cycle with r_rdata_o=r_rdata_i, r_opc_o=r_opc_i; other r_valid_o bits 0.
REQ-016 SHALL drive r_rdata_o and r_opc_o to 0 in cycles without r_valid_i.
REQ-017 SHALL accept a response no earlier than the cycle after its grant (zero-cycle response not supported; r_valid_i at grant cycle with empty FIFO is unexpected).
REQ-018 SHALL on r_valid_i with FIFO empty: assert no r_valid_o, set resp_err_o=1 until reset, leave count at 0.
REQ-019 SHALL handle push and pop in the same cycle: count unchanged, FIFO order preserved.
REQ-020 SHALL not push when full (req_o already 0); a pop while full frees a slot usable from the next cycle only.
REQ-021 SHALL keep outstanding_o equal to FIFO occupancy, updated at the clock edge after push/pop.
REQ-022 SHALL treat a master deasserting req_i while locked as a protocol violation; arbiter then releases lock and reselects by REQ-009 next cycle.

Reset
REQ-023 SHALL on rst_ni=0, asynchronously: ptr=0, lock cleared, FIFO empty, outstanding_o=0, resp_err_o=0, all gnt_o/r_valid_o=0, req_o=0.
REQ-024 SHALL discard pending responses on reset mid-operation; a response after reset release with empty FIFO follows REQ-018.

Verification
REQ-025 SHALL test: req_i=8'hFF held, gnt_i=1, r_valid_i one cycle after each grant -> grants to masters 0,1,...,7,0 in consecutive cycles, r_valid_o follows grant order.
REQ-026 SHALL test: req_i[3]=1, gnt_i=0 for 3 cycles, req_i[1] rises cycle 2 -> id_o=3 held all cycles, gnt_o[3] on first gnt_i=1, then master 1 served.
REQ-027 SHALL test: MAX_OUTSTANDING=2, two grants, no response -> outstanding_o=2, req_o=0 despite req_i; one r_valid_i -> req_o=1 next cycle.
REQ-028 SHALL test: grant to 5 then 2, responses r_rdata_i=32'hA5A5_0001 then 32'h0000_BEEF -> r_valid_o[5] with first data, r_valid_o[2] with second.
REQ-029 SHALL test: r_valid_i with empty FIFO -> no r_valid_o, resp_err_o=1 until rst_ni pulse.
REQ-030 SHALL test: rst_ni low with outstanding_o=1 -> all outputs zero immediately, ptr=0 so next req_i=8'h81 grants master 0.
